// File: rtl/ring_osc_freq_meter_if.sv
// Control/result bundle for the ring-oscillator frequency meter.
// master = sequencer/host side, slave = meter.
interface ring_osc_freq_meter_if #(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                   ena;
    logic                   start;
    logic [CH_W-1:0]        ch_sel;
    logic [4:0]             gate_log2;
    logic                   continuous;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] result;
    logic                   overflow;
    logic                   result_valid;

    modport master (
        output ena, start, ch_sel, gate_log2, continuous,
        input  busy, result, overflow, result_valid
    );

    modport slave (
        input  ena, start, ch_sel, gate_log2, continuous,
        output busy, result, overflow, result_valid
    );
endinterface

// File: rtl/ring_osc_freq_meter.sv
// Enables one ring, lets it settle, then counts its synchronised rising edges
// over a 2^g clk gate window and publishes the (saturating) count.
//
// state  | meaning
// IDLE   | all rings off, waiting for start with ena
// SETTLE | selected ring running, not counted yet
// GATE   | counting edges for 2^g cycles
// DONE   | result published this cycle; rearm or return to IDLE
module ring_osc_freq_meter #(
    parameter int NUM_CH        = 4,
    parameter int COUNT_WIDTH   = 16,
    parameter int GATE_MAX_LOG2 = 20,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    osc_in,
    output logic [NUM_CH-1:0]    osc_en,
    ring_osc_freq_meter_if.slave ctl
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CHX_W = CH_W + 1;
    localparam int GW    = GATE_MAX_LOG2 + 1;
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CHX_W-1:0] CH_MAX_X = CHX_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  CH_MAX   = CH_W'(NUM_CH - 1);
    localparam logic [4:0]       G_MAX    = 5'(GATE_MAX_LOG2);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic                   accept, enter_gate, finish;

    logic [NUM_CH-1:0]      sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]      sync_d;
    logic [NUM_CH-1:0]      edge_vec;
    logic                   edge_sel;

    logic [CH_W-1:0]        ch_q, ch_clamped;
    logic [4:0]             gate_q, gate_clamped;
    logic [SW-1:0]          settle_cnt;
    logic [GW-1:0]          gate_cnt, gate_len_m1;
    logic [COUNT_WIDTH-1:0] edge_cnt, cnt_final;
    logic                   sat, sat_final, cnt_full;

    // Edges faster than clk/2 alias; the meter does not try to detect that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sync_d <= '0;
        end else begin
            sync_q[0] <= osc_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_vec = sync_q[SYNC_STAGES-1] & ~sync_d;
    assign edge_sel = edge_vec[ch_q];

    assign ch_clamped   = ({1'b0, ctl.ch_sel} > CH_MAX_X) ? CH_MAX : ctl.ch_sel;
    assign gate_clamped = (ctl.gate_log2 > G_MAX) ? G_MAX : ctl.gate_log2;
    assign gate_len_m1  = (GW'(1) << gate_q) - GW'(1);

    assign cnt_full  = &edge_cnt;
    assign cnt_final = (edge_sel && !cnt_full) ? edge_cnt + 1'b1 : edge_cnt;
    assign sat_final = sat | (edge_sel & cnt_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        enter_gate = 1'b0;
        finish     = 1'b0;
        osc_en     = '0;
        ctl.busy   = (state != S_IDLE);
        if (state != S_IDLE) osc_en[ch_q] = 1'b1;
        unique case (state)
            S_IDLE: begin
                if (ctl.ena && ctl.start) begin
                    state_nxt = S_SETTLE;
                    accept    = 1'b1;
                end
            end
            S_SETTLE: begin
                if (!ctl.ena) begin
                    state_nxt = S_IDLE;
                end else if (settle_cnt == '0) begin
                    state_nxt  = S_GATE;
                    enter_gate = 1'b1;
                end
            end
            S_GATE: begin
                if (!ctl.ena) begin
                    state_nxt = S_IDLE;
                end else if (gate_cnt == '0) begin
                    state_nxt = S_DONE;
                    finish    = 1'b1;
                end
            end
            S_DONE: begin
                if (ctl.ena && ctl.continuous) begin
                    state_nxt  = S_GATE;
                    enter_gate = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result is registered on the last gate cycle so it and result_valid
    // are both visible during DONE, including that cycle's edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q             <= '0;
            gate_q           <= '0;
            settle_cnt       <= '0;
            gate_cnt         <= '0;
            edge_cnt         <= '0;
            sat              <= 1'b0;
            ctl.result       <= '0;
            ctl.overflow     <= 1'b0;
            ctl.result_valid <= 1'b0;
        end else begin
            ctl.result_valid <= finish;
            if (accept) begin
                ch_q       <= ch_clamped;
                gate_q     <= gate_clamped;
                settle_cnt <= SW'(SETTLE_CYCLES - 1);
            end else if (state == S_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (enter_gate) begin
                edge_cnt <= '0;
                sat      <= 1'b0;
                gate_cnt <= gate_len_m1;
            end else if (state == S_GATE) begin
                edge_cnt <= cnt_final;
                sat      <= sat_final;
                if (gate_cnt != '0) gate_cnt <= gate_cnt - 1'b1;
            end
            if (finish) begin
                ctl.result   <= cnt_final;
                ctl.overflow <= sat_final;
            end
        end
    end
endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Directed bench for ring_osc_freq_meter: 8-bit counter and 10-bit gate
// maximum keep overflow and clamp cases short.
module tb_ring_osc_freq_meter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] osc_in = '0;
    logic [3:0] osc_en;
    int         osc_mode [4] = '{0, 0, 0, 0};
    int         ph = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         rv_count = 0;
    int         n, base;

    ring_osc_freq_meter_if #(.NUM_CH(4), .COUNT_WIDTH(8)) ctl ();

    ring_osc_freq_meter #(
        .NUM_CH(4), .COUNT_WIDTH(8), .GATE_MAX_LOG2(10),
        .SETTLE_CYCLES(16), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .osc_en(osc_en), .ctl(ctl)
    );

    always #5 clk = ~clk;

    // mode 0: static low, 1: clk/2, 2: clk/4
    always @(negedge clk) begin
        ph = ph + 1;
        for (int i = 0; i < 4; i++) begin
            case (osc_mode[i])
                1:       osc_in[i] = ~osc_in[i];
                2:       if (ph % 2 == 0) osc_in[i] = ~osc_in[i];
                default: osc_in[i] = 1'b0;
            endcase
        end
    end

    always @(negedge clk) if (ctl.result_valid === 1'b1) rv_count = rv_count + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [1:0] ch, input logic [4:0] g);
        ctl.ch_sel    = ch;
        ctl.gate_log2 = g;
        ctl.start     = 1'b1;
        @(posedge clk);
        #1;
        ctl.start = 1'b0;
    endtask

    // Edges until result_valid is seen; 0 if the bound expires.
    task automatic wait_rv(input int max_c, output int cnt);
        cnt = 0;
        for (int i = 1; i <= max_c; i++) begin
            @(posedge clk);
            #1;
            if (ctl.result_valid === 1'b1) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        ctl.ena = 1'b0; ctl.start = 1'b0; ctl.ch_sel = '0;
        ctl.gate_log2 = '0; ctl.continuous = 1'b0;
        step(3);
        check("rst_busy", ctl.busy, 0);
        check("rst_osc_en", osc_en, 0);
        check("rst_result", ctl.result, 0);
        check("rst_overflow", ctl.overflow, 0);
        check("rst_rv", ctl.result_valid, 0);
        rst_n = 1'b1;
        ctl.ena = 1'b1;
        step(2);

        // Basic clk/4 measurement on channel 1
        osc_mode[1] = 2;
        step(4);
        do_start(2'd1, 5'd8);
        check("t1_osc_en", osc_en, 4'b0010);
        check("t1_busy", ctl.busy, 1);
        wait_rv(400, n);
        check("t1_latency", n + 1, 273);
        check("t1_result", ctl.result, 64);
        check("t1_overflow", ctl.overflow, 0);
        step(1);
        check("t1_osc_en_off", osc_en, 0);
        check("t1_busy_off", ctl.busy, 0);
        check("t1_rv_pulse", ctl.result_valid, 0);
        check("t1_result_hold", ctl.result, 64);

        // Saturation: 256 edges into an 8-bit counter, then recover
        do_start(2'd1, 5'd10);
        wait_rv(1200, n);
        check("t2_latency", n + 1, 1041);
        check("t2_result", ctl.result, 8'hFF);
        check("t2_overflow", ctl.overflow, 1);
        step(2);
        do_start(2'd1, 5'd8);
        wait_rv(400, n);
        check("t2b_result", ctl.result, 64);
        check("t2b_overflow", ctl.overflow, 0);
        step(2);

        // Continuous mode on a clk/2 input
        osc_mode[3] = 1;
        ctl.continuous = 1'b1;
        do_start(2'd3, 5'd4);
        wait_rv(100, n);
        check("t3_first_lat", n + 1, 33);
        check("t3_first_res", ctl.result, 8);
        for (int k = 0; k < 2; k++) begin
            wait_rv(40, n);
            check("t3_period", n, 17);
            check("t3_res", ctl.result, 8);
            check("t3_osc_en", osc_en, 4'b1000);
        end
        step(1);
        ctl.continuous = 1'b0;
        wait_rv(40, n);
        check("t3_last_period", n, 16);
        check("t3_last_res", ctl.result, 8);
        step(1);
        check("t3_idle_busy", ctl.busy, 0);
        check("t3_idle_osc_en", osc_en, 0);

        // gate_log2=0: one-cycle gate
        do_start(2'd3, 5'd0);
        wait_rv(40, n);
        check("t4_g0_latency", n + 1, 18);
        check("t4_g0_le1", ctl.result <= 8'd1, 1);
        step(2);

        // Second start mid-GATE is ignored
        base = rv_count;
        do_start(2'd1, 5'd6);
        step(29);
        do_start(2'd2, 5'd2);
        check("t5_osc_en", osc_en, 4'b0010);
        wait_rv(100, n);
        check("t5_latency", n + 31, 81);
        check("t5_result", ctl.result, 16);
        step(100);
        check("t5_one_rv", rv_count - base, 1);

        // Asynchronous reset mid-GATE
        do_start(2'd1, 5'd8);
        step(50);
        rst_n = 1'b0;
        #1;
        check("t6_rst_osc_en", osc_en, 0);
        check("t6_rst_busy", ctl.busy, 0);
        check("t6_rst_result", ctl.result, 0);
        step(2);
        rst_n = 1'b1;
        step(2);

        // ena low mid-SETTLE aborts without a result
        do_start(2'd1, 5'd4);
        wait_rv(40, n);
        check("t7_pre_result", ctl.result, 4);
        step(2);
        base = rv_count;
        do_start(2'd1, 5'd4);
        step(4);
        ctl.ena = 1'b0;
        step(1);
        check("t7_abort_busy", ctl.busy, 0);
        check("t7_abort_osc_en", osc_en, 0);
        ctl.start = 1'b1;
        step(1);
        ctl.start = 1'b0;
        check("t7_start_ena0", ctl.busy, 0);
        step(40);
        check("t7_no_rv", rv_count - base, 0);
        check("t7_result_held", ctl.result, 4);
        ctl.ena = 1'b1;
        step(2);

        // Channel isolation and gate clamp (31 behaves as 10)
        osc_mode[0] = 1;
        osc_mode[2] = 0;
        do_start(2'd2, 5'd31);
        check("t8_osc_en", osc_en, 4'b0100);
        wait_rv(1200, n);
        check("t8_latency", n + 1, 1041);
        check("t8_result", ctl.result, 0);
        check("t8_overflow", ctl.overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
